cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for a multi-lane common data bus (CDB).
// Functional units raise an early-tag request; up to CDB_WIDTH of them are
// granted per cycle in round-robin order, each granted FU owns one lane, and
// its result is broadcast on that lane exactly one cycle later. Any break in
// the grant/done handshake sets a sticky protocol_error.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,   // functional units competing for the CDB
  parameter int CDB_WIDTH  = 2,   // broadcast lanes, 1 <= CDB_WIDTH <= NUM_FU
  parameter int DATA_WIDTH = 32,  // width of one FU result
  parameter int META_WIDTH = 16   // width of one completion-metadata entry
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_FU-1:0]                     fu_request,
  output logic [NUM_FU-1:0]                     fu_grant,
  input  logic [NUM_FU-1:0]                     fu_done,
  input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]     fu_result,
  input  logic [NUM_FU-1:0][META_WIDTH-1:0]     fu_meta,
  output logic [CDB_WIDTH-1:0]                  cdb_valid,
  output logic [CDB_WIDTH-1:0][DATA_WIDTH-1:0]  cdb_data,
  output logic [CDB_WIDTH-1:0][META_WIDTH-1:0]  cdb_meta,
  output logic                                  protocol_error
);

  // FU index width; a single-FU build still needs a 1-bit index.
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  // Wide enough to count every requester, 0..NUM_FU.
  localparam int CNT_W = $clog2(NUM_FU + 1);

  typedef logic [PTR_W-1:0] fu_idx_t;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  fu_idx_t                  rr_ptr;     // first FU examined by the next scan
  logic [CDB_WIDTH-1:0]     lane_pend;  // lane was assigned at the last edge
  fu_idx_t [CDB_WIDTH-1:0]  lane_fu;    // FU that owns each pending lane

  // ---------------------------------------------------------------------------
  // Arbitration signals (current cycle)
  // ---------------------------------------------------------------------------
  fu_idx_t [NUM_FU-1:0]         rot_fu;     // scan slot -> FU index
  logic    [NUM_FU-1:0]         req_rot;    // requests in scan order
  logic    [NUM_FU-1:0][CNT_W-1:0] rank;    // requesters ahead in scan order
  logic    [NUM_FU-1:0]         grant_rot;  // grants in scan order
  logic    [NUM_FU-1:0]         grant_raw;  // grants in FU order, before reset gating
  logic    [CDB_WIDTH-1:0]      assign_pend;
  fu_idx_t [CDB_WIDTH-1:0]      assign_fu;
  logic                         any_grant;
  fu_idx_t                      last_fu;
  fu_idx_t                      next_ptr;

  // ---------------------------------------------------------------------------
  // Broadcast / handshake-check signals
  // ---------------------------------------------------------------------------
  logic [CDB_WIDTH-1:0] lane_done;     // done seen from the FU owning the lane
  logic [NUM_FU-1:0]    fu_claimed;    // FU owns some pending lane
  logic                 stray_done;    // done with no pending lane behind it
  logic                 missing_done;  // pending lane whose FU stayed silent

  // Map scan slots to FUs and rank every requester by its position in the scan.
  always_comb begin
    logic [CNT_W-1:0] seen;
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path through the block can leave a latch behind.
    rot_fu    = '0;
    req_rot   = '0;
    rank      = '0;
    grant_rot = '0;
    seen      = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      rot_fu[off]    = fu_idx_t'((int'(rr_ptr) + off) % NUM_FU);
      req_rot[off]   = fu_request[rot_fu[off]];
      rank[off]      = seen;
      grant_rot[off] = req_rot[off] && (seen < CNT_W'(CDB_WIDTH));
      seen           = seen + CNT_W'(req_rot[off]);
    end
  end

  // Turn scan-order grants into per-FU grants, lane assignments and the next pointer.
  always_comb begin
    grant_raw   = '0;
    assign_pend = '0;
    assign_fu   = '0;
    any_grant   = 1'b0;
    last_fu     = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      if (grant_rot[off]) begin
        grant_raw[rot_fu[off]] = 1'b1;
        any_grant              = 1'b1;
        last_fu                = rot_fu[off];  // later slots overwrite earlier ones
      end
    end
    // The k-th granted FU in scan order owns lane k.
    for (int k = 0; k < CDB_WIDTH; k++) begin
      for (int off = 0; off < NUM_FU; off++) begin
        if (grant_rot[off] && (rank[off] == CNT_W'(k))) begin
          assign_pend[k] = 1'b1;
          assign_fu[k]   = rot_fu[off];
        end
      end
    end
    next_ptr = any_grant ? fu_idx_t'((int'(last_fu) + 1) % NUM_FU) : rr_ptr;
  end

  // Reset suppresses grants immediately, even with requests already raised.
  always_comb begin
    fu_grant = reset ? '0 : grant_raw;
  end

  // Broadcast each pending lane when its FU delivers, muxing that FU's result.
  always_comb begin
    lane_done = '0;
    cdb_valid = '0;
    cdb_data  = '0;
    cdb_meta  = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      lane_done[k] = fu_done[lane_fu[k]];
      if (lane_pend[k] && lane_done[k]) begin
        cdb_valid[k] = 1'b1;
        cdb_data[k]  = fu_result[lane_fu[k]];
        cdb_meta[k]  = fu_meta[lane_fu[k]];
      end
    end
  end

  // Detect done pulses nobody is waiting for and lanes whose FU never answered.
  always_comb begin
    fu_claimed = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (lane_pend[k] && (lane_fu[k] == fu_idx_t'(i))) begin
          fu_claimed[i] = 1'b1;
        end
      end
    end
    stray_done   = |(fu_done & ~fu_claimed);
    missing_done = |(lane_pend & ~lane_done);
  end

  // Advance the round-robin pointer and capture this cycle's lane ownership.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      lane_pend <= '0;
      lane_fu   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      rr_ptr    <= next_ptr;
      lane_pend <= assign_pend;
      lane_fu   <= assign_fu;
    end
  end

  // Sticky handshake-violation flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if (stray_done || missing_done) begin
      protocol_error <= 1'b1;
    end
  end

endmodule
